sbox_subst_unit: RTL and testbench

SBOX_SUBST_UNIT -- requirements
Module: sbox_subst_unit

---
 rtl/des_pkg.sv | 42 ++++
 rtl/sbox_lut.sv | 31 +++
 rtl/sbox_subst_unit.sv | 122 ++++++++++++
 tb/tb_sbox_subst_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_pkg
// Purpose  : DES S-box tables, row/col index helper and lane-count limit.
// Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int SBOX_NUM_MAX = 8;

    // Index 0 sits at the most significant end, so each row literal reads
    // left to right as columns 0..15.
    typedef logic [0:15][3:0]           sbox_row_t;
    typedef sbox_row_t [0:3]            sbox_t;
    typedef sbox_t [0:SBOX_NUM_MAX-1]   sbox_set_t;

    localparam sbox_set_t c_sbox_tbl = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
          64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},   // S1
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
          64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},   // S2
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1,
          64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},   // S3
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
          64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},   // S4
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
          64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},   // S5
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
          64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},   // S6
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
          64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},   // S7
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}    // S8
    };

    // Returns {row[1:0], col[3:0]} for a 6-bit S-box address.
    function automatic logic [5:0] sbox_index(input logic [5:0] a);
        return {a[5], a[0], a[4:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_lut.sv
`default_nettype none
// ============================================================================
// Module   : sbox_lut
// Purpose  : Combinational single-lane S-box lookup; BOX selects S(BOX+1).
//            With SBOX_PROG_EN the lookup reads the live register tables.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_lut
    import des_pkg::*;
#(
    parameter int BOX = 0
) (
`ifdef SBOX_PROG_EN
    input  sbox_set_t   tbl,
`endif
    input  logic [5:0]  addr,
    output logic [3:0]  data
);

    logic [5:0] w_idx;

    assign w_idx = sbox_index(addr);

`ifdef SBOX_PROG_EN
    assign data = tbl[BOX][w_idx[5:4]][w_idx[3:0]];
`else
    assign data = c_sbox_tbl[BOX][w_idx[5:4]][w_idx[3:0]];
`endif

endmodule
`default_nettype wire

// File: rtl/sbox_subst_unit.sv
`default_nettype none
// ============================================================================
// Module   : sbox_subst_unit
// Purpose  : NUM_SBOX parallel DES S-box lanes feeding a FIFO_DEPTH output
//            buffer with valid/ready handshakes. SBOX_PROG_EN adds cfg_* ports
//            and register-held, reprogrammable tables.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_subst_unit
    import des_pkg::*;
#(
    parameter int NUM_SBOX   = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6*NUM_SBOX-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_SBOX-1:0]   out_data
`ifdef SBOX_PROG_EN
    ,
    input  logic                    cfg_we,
    input  logic [2:0]              cfg_sel,
    input  logic [5:0]              cfg_addr,
    input  logic [3:0]              cfg_data
`endif
);

    localparam int c_dw    = 4 * NUM_SBOX;
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    logic [c_dw-1:0]    w_result;
    logic [c_dw-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [c_dw-1:0]    r_out_data;

    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_cnt_after_pop;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [c_ptr_w-1:0] w_rd_next;
    logic [c_dw-1:0]    w_head_next;

`ifdef SBOX_PROG_EN
    sbox_set_t  r_tbl;
    logic [5:0] w_cfg_idx;

    assign w_cfg_idx = sbox_index(cfg_addr);

    // A lookup in the write cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tbl <= c_sbox_tbl;
        end else if (cfg_we) begin
            r_tbl[cfg_sel][w_cfg_idx[5:4]][w_cfg_idx[3:0]] <= cfg_data;
        end
    end
`endif

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
        sbox_lut #(
            .BOX (NUM_SBOX - 1 - k)
        ) u_lut (
`ifdef SBOX_PROG_EN
            .tbl  (r_tbl),
`endif
            .addr (in_data[6*k +: 6]),
            .data (w_result[4*k +: 4])
        );
    end

    assign w_push          = in_valid & r_in_ready;
    assign w_pop           = r_out_valid & out_ready;
    assign w_cnt_after_pop = r_count - c_cnt_w'(w_pop);
    assign w_cnt_next      = w_cnt_after_pop + c_cnt_w'(w_push);
    assign w_rd_next       = r_rd_ptr + c_ptr_w'(w_pop);
    // If the buffer drains this cycle, the incoming word becomes the new head.
    assign w_head_next     = (w_cnt_after_pop == '0) ? w_result : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_cnt_next;
            r_in_ready  <= (w_cnt_next < c_depth);
            r_out_valid <= (w_cnt_next != '0);
            if (w_cnt_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sbox_subst_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_subst_unit
// Purpose  : Directed self-checking bench for sbox_subst_unit (default
//            parameters); the SBOX_PROG_EN section runs only with that macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbox_subst_unit;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [47:0] in_data   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
`ifdef SBOX_PROG_EN
    logic        cfg_we    = 1'b0;
    logic [2:0]  cfg_sel   = '0;
    logic [5:0]  cfg_addr  = '0;
    logic [3:0]  cfg_data  = '0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] vin  [6];
    logic [31:0] vexp [6];

    sbox_subst_unit #(
        .NUM_SBOX   (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SBOX_PROG_EN
        ,
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vin[0] = 48'h0000_0000_0000;  vexp[0] = 32'hEFA72C4D;
        vin[1] = 48'hFFFF_FFFF_FFFF;  vexp[1] = 32'hD9CE3DCB;
        vin[2] = 48'h0000_4000_0000;  vexp[2] = 32'hEFD72C4D;  // S3 lane 000001 -> 13
        vin[3] = 48'h0008_0000_0000;  vexp[3] = 32'hEFD72C4D;  // S3 lane 100000 -> 13
        vin[4] = 48'h0000_0000_0002;  vexp[4] = 32'hEFA72C42;  // S8 row0 col1 -> 2
        vin[5] = 48'h7800_0000_0000;  vexp[5] = 32'h7FA72C4D;  // S1 row0 col15 -> 7

        // reset state
        tick; tick;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data,           32'd0);
        rst_n = 1'b1;
        tick;

        // single word, 1-cycle latency, then hold on empty
        out_ready = 1'b1; in_valid = 1'b1; in_data = vin[0];
        tick;
        in_valid = 1'b0; in_data = vin[1];
        check("lat_valid", {31'd0, out_valid}, 32'd1);
        check("lat_data",  out_data,           32'hEFA72C4D);
        tick;
        check("empty_valid", {31'd0, out_valid}, 32'd0);
        check("empty_hold",  out_data,           32'hEFA72C4D);

        // back-to-back stream at one word per cycle
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            tick;
            check($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream%0d_data", i),  out_data,           vexp[i]);
            check($sformatf("stream%0d_ready", i), {31'd0, in_ready},  32'd1);
        end
        in_valid = 1'b0;
        tick;
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // backpressure: third word must wait for space
        out_ready = 1'b0; in_valid = 1'b1; in_data = vin[0];
        tick;
        in_data = vin[1];
        tick;
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold1",      out_data,          32'hEFA72C4D);
        in_data = vin[4];
        tick;
        check("bp_still_full", {31'd0, in_ready}, 32'd0);
        check("bp_hold2",      out_data,          32'hEFA72C4D);
        out_ready = 1'b1;
        tick;
        check("bp_first_out",  out_data,          32'hD9CE3DCB);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        check("bp_third_valid", {31'd0, out_valid}, 32'd1);
        check("bp_third_data",  out_data,           32'hEFA72C42);
        tick;
        check("bp_no_dup", {31'd0, out_valid}, 32'd0);

        // reset with two results buffered
        out_ready = 1'b0; in_valid = 1'b1; in_data = vin[1];
        tick;
        in_data = vin[5];
        tick;
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick;
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("mrst_out_data",  out_data,           32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        tick;
        check("mrst_no_stale1", {31'd0, out_valid}, 32'd0);
        tick;
        check("mrst_no_stale2", {31'd0, out_valid}, 32'd0);

`ifdef SBOX_PROG_EN
        // table write: same-cycle word sees old entry, next word sees new one
        cfg_we = 1'b1; cfg_sel = 3'd2; cfg_addr = 6'd0; cfg_data = 4'h5;
        in_valid = 1'b1; in_data = vin[0];
        tick;
        cfg_we = 1'b0;
        check("prog_old", out_data, 32'hEFA72C4D);
        tick;
        in_valid = 1'b0;
        check("prog_new", out_data, 32'hEF572C4D);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        in_valid = 1'b1; in_data = vin[0];
        tick;
        in_valid = 1'b0;
        check("prog_restored", out_data, 32'hEFA72C4D);
        tick;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
